// File: rtl/uart_motion_controller_if.sv
// Byte handshake bundle between the UART receiver/transmitter and the motion controller.
// The controller takes the slave side: it consumes rx bytes and produces echo bytes.
interface uart_motion_controller_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        output tx_ready,
        input  rx_ready,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        output rx_ready,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/uart_motion_controller.sv
// Keyboard-to-motion controller: echoes every accepted byte, decodes single-key and ANSI
// arrow-key commands, and keeps clamped signed X/Y offsets for NUM_CH movable objects.
module uart_motion_controller #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned OFF_WIDTH = 12,
    parameter int unsigned STEP_INIT = 5,
    parameter int unsigned STEP_MAX  = 64,
    parameter int unsigned X_LIMIT   = 800,
    parameter int unsigned Y_LIMIT   = 600
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_motion_controller_if.slave       bus,
    output logic [NUM_CH*OFF_WIDTH-1:0]   x_off,
    output logic [NUM_CH*OFF_WIDTH-1:0]   y_off,
    output logic [2:0]                    sel,
    output logic [7:0]                    step,
    output logic [3:0]                    key_event
);

    typedef enum logic [1:0] {StIdle, StEsc, StCsi} state_t;

    localparam logic signed [OFF_WIDTH:0] XLim     = (OFF_WIDTH + 1)'(X_LIMIT);
    localparam logic signed [OFF_WIDTH:0] YLim     = (OFF_WIDTH + 1)'(Y_LIMIT);
    localparam logic [8:0]                StepMax9 = 9'(STEP_MAX);
    localparam logic [7:0]                StepMax8 = 8'(STEP_MAX);
    localparam logic [7:0]                StepInit = 8'(STEP_INIT);

    // Direction one-hot layout, shared with key_event: {up, down, left, right}
    localparam logic [3:0] DirUp    = 4'b1000;
    localparam logic [3:0] DirDown  = 4'b0100;
    localparam logic [3:0] DirLeft  = 4'b0010;
    localparam logic [3:0] DirRight = 4'b0001;

    state_t state_q, state_d;

    logic [7:0] tx_data_q;
    logic       tx_valid_q;
    logic       rx_ready_w;
    logic       fire;

    logic signed [OFF_WIDTH-1:0] x_q [NUM_CH];
    logic signed [OFF_WIDTH-1:0] x_d [NUM_CH];
    logic signed [OFF_WIDTH-1:0] y_q [NUM_CH];
    logic signed [OFF_WIDTH-1:0] y_d [NUM_CH];

    logic [2:0] sel_q, sel_d;
    logic [7:0] step_q, step_d;
    logic [3:0] key_event_q, key_event_d;

    // Decoded command strobes, valid only in the fire cycle
    logic [3:0] mv;
    logic       sel_load;
    logic       step_inc;
    logic       step_dec;
    logic       clr_one;
    logic       clr_all;

    logic [8:0] step_dbl;
    logic [7:0] step_half;

    // Add or subtract the step with one guard bit, then clamp to +/-lim; never wraps.
    function automatic logic signed [OFF_WIDTH-1:0] move_clamp(
        input logic signed [OFF_WIDTH-1:0] cur,
        input logic                        subtract,
        input logic [7:0]                  amt,
        input logic signed [OFF_WIDTH:0]   lim
    );
        logic signed [OFF_WIDTH:0] wide;
        logic signed [OFF_WIDTH:0] delta;
        logic signed [OFF_WIDTH:0] sum;
        logic signed [OFF_WIDTH:0] neg_lim;
        wide    = {cur[OFF_WIDTH-1], cur};
        delta   = $signed({{(OFF_WIDTH - 7){1'b0}}, amt});
        neg_lim = -lim;
        sum     = subtract ? (wide - delta) : (wide + delta);
        if (sum > lim) begin
            sum = lim;
        end else if (sum < neg_lim) begin
            sum = neg_lim;
        end
        return sum[OFF_WIDTH-1:0];
    endfunction

    assign rx_ready_w   = ~tx_valid_q | bus.tx_ready;
    assign fire         = bus.rx_valid & rx_ready_w;
    assign bus.rx_ready = rx_ready_w;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;

    assign sel       = sel_q;
    assign step      = step_q;
    assign key_event = key_event_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
        assign x_off[k*OFF_WIDTH +: OFF_WIDTH] = x_q[k];
        assign y_off[k*OFF_WIDTH +: OFF_WIDTH] = y_q[k];
    end

    // Echo register: accept when empty or draining; a same-cycle fire replaces the old byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else if (fire) begin
            tx_data_q  <= bus.rx_data;
            tx_valid_q <= 1'b1;
        end else if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
        end
    end

    // Decode FSM next state and command strobes; nothing happens without a fire.
    always_comb begin
        state_d  = state_q;
        mv       = 4'b0000;
        sel_load = 1'b0;
        step_inc = 1'b0;
        step_dec = 1'b0;
        clr_one  = 1'b0;
        clr_all  = 1'b0;
        if (fire) begin
            case (state_q)
                StIdle: begin
                    case (bus.rx_data)
                        8'h1B: state_d  = StEsc;
                        8'h77: mv       = DirUp;
                        8'h73: mv       = DirDown;
                        8'h61: mv       = DirLeft;
                        8'h64: mv       = DirRight;
                        8'h30, 8'h31, 8'h32, 8'h33,
                        8'h34, 8'h35, 8'h36, 8'h37:
                               sel_load = (32'(bus.rx_data[2:0]) < NUM_CH);
                        8'h2B: step_inc = 1'b1;
                        8'h2D: step_dec = 1'b1;
                        8'h72: clr_one  = 1'b1;
                        8'h52: clr_all  = 1'b1;
                        default: ;
                    endcase
                end
                StEsc: begin
                    state_d = (bus.rx_data == 8'h5B) ? StCsi : StIdle;
                end
                StCsi: begin
                    state_d = StIdle;
                    case (bus.rx_data)
                        8'h41:   mv = DirUp;
                        8'h42:   mv = DirDown;
                        8'h43:   mv = DirRight;
                        8'h44:   mv = DirLeft;
                        default: ;
                    endcase
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Channel select, step size and last-direction next state.
    always_comb begin
        sel_d       = sel_q;
        step_d      = step_q;
        key_event_d = key_event_q;
        step_dbl    = {step_q, 1'b0};
        step_half   = step_q >> 1;
        if (sel_load) begin
            sel_d = bus.rx_data[2:0];
        end
        if (step_inc) begin
            step_d = (step_dbl > StepMax9) ? StepMax8 : step_dbl[7:0];
        end else if (step_dec) begin
            step_d = (step_half == 8'd0) ? 8'd1 : step_half;
        end
        if (|mv) begin
            key_event_d = mv;
        end
    end

    // Offset next state: clears take priority, moves touch only the selected channel.
    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            x_d[k] = x_q[k];
            y_d[k] = y_q[k];
            if (clr_all || (clr_one && (32'(sel_q) == k))) begin
                x_d[k] = '0;
                y_d[k] = '0;
            end else if (32'(sel_q) == k) begin
                if (mv[1]) x_d[k] = move_clamp(x_q[k], 1'b1, step_q, XLim);
                if (mv[0]) x_d[k] = move_clamp(x_q[k], 1'b0, step_q, XLim);
                if (mv[3]) y_d[k] = move_clamp(y_q[k], 1'b1, step_q, YLim);
                if (mv[2]) y_d[k] = move_clamp(y_q[k], 1'b0, step_q, YLim);
            end
        end
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sel_q       <= 3'd0;
            step_q      <= StepInit;
            key_event_q <= 4'b0000;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            step_q      <= step_d;
            key_event_q <= key_event_d;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                x_q[k] <= x_d[k];
                y_q[k] <= y_d[k];
            end
        end
    end

endmodule

// File: tb/tb_uart_motion_controller.sv
// Directed bench for uart_motion_controller with default parameters.
module tb_uart_motion_controller;

    localparam int W = 12;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [N*W-1:0] x_off;
    logic [N*W-1:0] y_off;
    logic [2:0]     sel;
    logic [7:0]     step;
    logic [3:0]     key_event;

    int checks = 0;
    int errors = 0;

    uart_motion_controller_if bus ();

    uart_motion_controller dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .x_off     (x_off),
        .y_off     (y_off),
        .sel       (sel),
        .step      (step),
        .key_event (key_event)
    );

    always #5 clk = ~clk;

    function automatic logic signed [W-1:0] xo(input int k);
        return x_off[k*W +: W];
    endfunction

    function automatic logic signed [W-1:0] yo(input int k);
        return y_off[k*W +: W];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one byte and hold it until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (!bus.rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rx_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h never accepted, rx_ready=%b required 1", b,
                     bus.rx_ready);
            bus.rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (x_off !== '0 || y_off !== '0) begin
            errors++;
            $display("FAIL reset_offsets: x=%h y=%h required 0", x_off, y_off);
        end
        checks++;
        if (sel !== 3'd0 || step !== 8'd5 || key_event !== 4'b0000) begin
            errors++;
            $display("FAIL reset_regs: sel=%0d step=%0d key=%b required 0/5/0000",
                     sel, step, key_event);
        end
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || bus.rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_echo: tx_valid=%b tx_data=%h rx_ready=%b required 0/00/1",
                     bus.tx_valid, bus.tx_data, bus.rx_ready);
        end
    endtask

    task automatic test_move_right();
        for (int i = 0; i < 3; i++) begin
            send(8'h64);
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h64) begin
                errors++;
                $display("FAIL echo_d%0d: tx_valid=%b tx_data=%h required 1/64", i,
                         bus.tx_valid, bus.tx_data);
            end
        end
        checks++;
        if (xo(0) !== 12'sd15 || yo(0) !== 12'sd0 || key_event !== 4'b0001) begin
            errors++;
            $display("FAIL move_right: x0=%0d y0=%0d key=%b required 15/0/0001",
                     xo(0), yo(0), key_event);
        end
    endtask

    task automatic test_step_clamp();
        logic [7:0] exp_step [5];
        exp_step[0] = 8'd10;
        exp_step[1] = 8'd20;
        exp_step[2] = 8'd40;
        exp_step[3] = 8'd64;
        exp_step[4] = 8'd64;
        for (int i = 0; i < 5; i++) begin
            send(8'h2B);
            checks++;
            if (step !== exp_step[i]) begin
                errors++;
                $display("FAIL step_inc%0d: step=%0d required %0d", i, step, exp_step[i]);
            end
        end
        for (int i = 0; i < 12; i++) send(8'h64);
        checks++;
        if (xo(0) !== 12'sd783) begin
            errors++;
            $display("FAIL x_near_limit: x0=%0d required 783", xo(0));
        end
        send(8'h64);
        checks++;
        if (xo(0) !== 12'sd800) begin
            errors++;
            $display("FAIL x_clamp_hi: x0=%0d required 800", xo(0));
        end
        for (int i = 0; i < 10; i++) send(8'h77);
        checks++;
        if (yo(0) !== -12'sd600 || key_event !== 4'b1000) begin
            errors++;
            $display("FAIL y_clamp_lo: y0=%0d key=%b required -600/1000", yo(0), key_event);
        end
        send(8'h2D);
        checks++;
        if (step !== 8'd32) begin
            errors++;
            $display("FAIL step_dec_first: step=%0d required 32", step);
        end
        for (int i = 0; i < 7; i++) send(8'h2D);
        checks++;
        if (step !== 8'd1 || key_event !== 4'b1000) begin
            errors++;
            $display("FAIL step_dec_floor: step=%0d key=%b required 1/1000", step, key_event);
        end
    endtask

    task automatic test_channels();
        send(8'h64);
        send(8'h32);
        send(8'h61);
        checks++;
        if (sel !== 3'd2 || xo(2) !== -12'sd5 || key_event !== 4'b0010) begin
            errors++;
            $display("FAIL sel_move: sel=%0d x2=%0d key=%b required 2/-5/0010",
                     sel, xo(2), key_event);
        end
        checks++;
        if (xo(0) !== 12'sd5 || xo(1) !== 12'sd0 || xo(3) !== 12'sd0 || y_off !== '0) begin
            errors++;
            $display("FAIL other_channels: x=%h y=%h required x0=5 x1=x3=0 y=0", x_off, y_off);
        end
        send(8'h35);
        checks++;
        if (sel !== 3'd2) begin
            errors++;
            $display("FAIL sel_out_of_range: sel=%0d required 2", sel);
        end
        send(8'h72);
        checks++;
        if (xo(2) !== 12'sd0 || xo(0) !== 12'sd5 || key_event !== 4'b0010) begin
            errors++;
            $display("FAIL clear_one: x2=%0d x0=%0d key=%b required 0/5/0010",
                     xo(2), xo(0), key_event);
        end
        send(8'h52);
        checks++;
        if (x_off !== '0 || y_off !== '0) begin
            errors++;
            $display("FAIL clear_all: x=%h y=%h required 0", x_off, y_off);
        end
    endtask

    task automatic test_escape();
        logic [7:0] seq [3];
        seq[0] = 8'h1B;
        seq[1] = 8'h5B;
        seq[2] = 8'h41;
        for (int i = 0; i < 3; i++) begin
            send(seq[i]);
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== seq[i]) begin
                errors++;
                $display("FAIL esc_echo%0d: tx_data=%h tx_valid=%b required %h/1", i,
                         bus.tx_data, bus.tx_valid, seq[i]);
            end
        end
        checks++;
        if (yo(0) !== -12'sd5 || key_event !== 4'b1000) begin
            errors++;
            $display("FAIL csi_up: y0=%0d key=%b required -5/1000", yo(0), key_event);
        end
        send(8'h1B);
        send(8'h78);
        checks++;
        if (xo(0) !== 12'sd0 || key_event !== 4'b1000) begin
            errors++;
            $display("FAIL esc_abort: x0=%0d key=%b required 0/1000", xo(0), key_event);
        end
        send(8'h64);
        checks++;
        if (xo(0) !== 12'sd5 || key_event !== 4'b0001) begin
            errors++;
            $display("FAIL after_abort: x0=%0d key=%b required 5/0001", xo(0), key_event);
        end
        send(8'h1B);
        send(8'h77);
        checks++;
        if (yo(0) !== -12'sd5) begin
            errors++;
            $display("FAIL esc_no_reinterpret: y0=%0d required -5", yo(0));
        end
        send(8'h1B);
        send(8'h5B);
        send(8'h43);
        checks++;
        if (xo(0) !== 12'sd10 || key_event !== 4'b0001) begin
            errors++;
            $display("FAIL csi_right: x0=%0d key=%b required 10/0001", xo(0), key_event);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [3];
        seq[0] = 8'h64;
        seq[1] = 8'h77;
        seq[2] = 8'h61;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.rx_data = seq[i];
            @(posedge clk);
            #1;
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== seq[i]) begin
                errors++;
                $display("FAIL b2b_echo%0d: tx_data=%h tx_valid=%b required %h/1", i,
                         bus.tx_data, bus.tx_valid, seq[i]);
            end
        end
        bus.rx_valid = 1'b0;
        checks++;
        if (xo(0) !== 12'sd0 || yo(0) !== -12'sd5 || key_event !== 4'b0010) begin
            errors++;
            $display("FAIL b2b_moves: x0=%0d y0=%0d key=%b required 0/-5/0010",
                     xo(0), yo(0), key_event);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: tx_valid=%b required 0", bus.tx_valid);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        bus.tx_ready = 1'b0;
        send(8'h77);
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.rx_ready !== 1'b0 || bus.tx_data !== 8'h77) begin
            errors++;
            $display("FAIL bp_hold: tx_valid=%b rx_ready=%b tx_data=%h required 1/0/77",
                     bus.tx_valid, bus.rx_ready, bus.tx_data);
        end
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h61;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rx_ready !== 1'b0 || bus.tx_data !== 8'h77 || xo(0) !== 12'sd0) begin
                errors++;
                $display("FAIL bp_stall%0d: rx_ready=%b tx_data=%h x0=%0d required 0/77/0", i,
                         bus.rx_ready, bus.tx_data, xo(0));
            end
        end
        bus.tx_ready = 1'b1;
        #1;
        checks++;
        if (bus.rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: rx_ready=%b required 1", bus.rx_ready);
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        checks++;
        if (bus.tx_data !== 8'h61 || xo(0) !== -12'sd5 || yo(0) !== -12'sd5) begin
            errors++;
            $display("FAIL bp_accept: tx_data=%h x0=%0d y0=%0d required 61/-5/-5",
                     bus.tx_data, xo(0), yo(0));
        end
    endtask

    task automatic test_reset_mid();
        send(8'h1B);
        send(8'h5B);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_echo: tx_valid=%b rx_ready=%b required 0/1",
                     bus.tx_valid, bus.rx_ready);
        end
        send(8'h41);
        checks++;
        if (yo(0) !== 12'sd0 || key_event !== 4'b0000 || bus.tx_data !== 8'h41) begin
            errors++;
            $display("FAIL mid_reset_seq: y0=%0d key=%b tx_data=%h required 0/0000/41",
                     yo(0), key_event, bus.tx_data);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h64;
        @(posedge clk);
        #1;
        checks++;
        if (xo(0) !== 12'sd0 || bus.tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_priority: x0=%0d tx_valid=%b required 0/0", xo(0), bus.tx_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.rx_valid = 1'b0;
        send(8'h64);
        checks++;
        if (xo(0) !== 12'sd5 || key_event !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_idle: x0=%0d key=%b required 5/0001", xo(0), key_event);
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;
        test_reset();
        test_move_right();
        test_step_clamp();
        do_reset();
        test_channels();
        do_reset();
        test_escape();
        do_reset();
        test_back_to_back();
        do_reset();
        test_backpressure();
        do_reset();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_motion_controller.md
# uart_motion_controller

Parametrised keyboard-to-motion controller sitting between `uart_receiver` and `uart_transmitter` in the pixel-clock domain. Echoes every received byte and decodes single-key commands (w/a/s/d), ANSI arrow-key escape sequences, channel-select, step-size and recenter keys. Maintains clamped, signed X/Y offsets for `NUM_CH` independently movable objects, such as triangle or sprite vertex groups, and feeds them to the drawing blocks.

## Interface
- `NUM_CH`, 4: number of object channels, 1..8.
- `OFF_WIDTH`, 12: signed offset width; must satisfy max(`X_LIMIT`,`Y_LIMIT`) + `STEP_MAX` < 2^(`OFF_WIDTH`-1).
- `STEP_INIT`, 5: step after reset, 1..`STEP_MAX`.
- `STEP_MAX`, 64: step ceiling, ≤255.
- `X_LIMIT`, 800: x offsets clamp to [-`X_LIMIT`, +`X_LIMIT`].
- `Y_LIMIT`, 600: y offsets clamp to [-`Y_LIMIT`, +`Y_LIMIT`].

Ports:
- `clk` in 1: pixel clock; all logic on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `rx_data` in 8: byte from `uart_receiver`.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: byte accepted when `rx_valid & rx_ready` (fire).
- `tx_data` out 8: echo byte to `uart_transmitter`.
- `tx_valid` out 1: echo byte valid.
- `tx_ready` in 1: transmitter ready.
- `x_off` out `NUM_CH*OFF_WIDTH`: packed signed x offsets; channel k at bits [k*`OFF_WIDTH` +: `OFF_WIDTH`].
- `y_off` out `NUM_CH*OFF_WIDTH`: packed signed y offsets, same packing.
- `sel` out 3: active channel index.
- `step` out 8: current step size.
- `key_event` out 4: {up, down, left, right}, one-hot of the last applied direction command.

## Operation
- Echo: a one-entry register. `rx_ready = ~tx_valid | tx_ready` (combinational).
  - On fire: `tx_data` ← `rx_data`, `tx_valid` ← 1.
  - On `tx_valid & tx_ready` with no new fire: `tx_valid` ← 0.
  - Every accepted byte is echoed, including escape bytes and ignored bytes.
- Decode FSM (advances only on fire): states `S_IDLE`, `S_ESC`, `S_CSI`.
  - `S_IDLE`:
    - 0x1B → `S_ESC`.
    - `w` (0x77) up; `s` (0x73) down; `a` (0x61) left; `d` (0x64) right.
    - `0`..`7` (0x30+k): `sel` ← k if k < `NUM_CH`, else ignored.
    - `+` (0x2B): `step` ← min(2·`step`, `STEP_MAX`).
    - `-` (0x2D): `step` ← max(`step`>>1, 1).
    - `r` (0x72): zero both offsets of channel `sel`.
    - `R` (0x52): zero all offsets.
    - Any other byte: ignored. State remains `S_IDLE`.
  - `S_ESC`: `[` (0x5B) → `S_CSI`. Any other byte → `S_IDLE`, no action; the byte is not reinterpreted as a command.
  - `S_CSI`: `A` up, `B` down, `C` right, `D` left, then → `S_IDLE`. Any other byte → `S_IDLE`, no action.
- Direction commands act on channel `sel` only:
  - up: y −= `step`; down: y += `step`; left: x −= `step`; right: x += `step`.
  - Arithmetic is computed in `OFF_WIDTH`+1 signed bits, then clamped to ±LIMIT of that axis. Never wraps.
  - `key_event` ← matching one-hot, held until the next direction command. Non-direction commands leave it unchanged.
- Reset values: all `x_off`/`y_off` = 0, `sel` = 0, `step` = `STEP_INIT`, FSM = `S_IDLE`, `tx_valid` = 0, `tx_data` = 0, `key_event` = 0. `rx_ready` = 1 after reset.
- Reset mid-operation: a pending echo byte is dropped and a partial escape sequence is abandoned. `rst` has priority over a same-cycle fire.

## Timing
- Fire in cycle n:
  - `tx_valid`/`tx_data` updated at edge n+1.
  - offsets, `sel`, `step`, `key_event` and FSM state updated at edge n+1.
  - Command latency is 1 cycle.
- Throughput: one byte per cycle while `tx_ready` = 1.
- With `tx_ready` = 0 and `tx_valid` = 1: `rx_ready` = 0, and `tx_data` is held stable until the transfer completes.
- A fire and an echo drain in the same cycle: the new byte replaces the old one, and `tx_valid` stays 1.
- All outputs are registered except `rx_ready`.

## Test plan
- Reset, then `d`,`d`,`d` with `tx_ready` = 1 → `x_off[0]` = 15, `y_off[0]` = 0, `key_event` = 4'b0001; echo bytes 0x64 ×3 in order.
- `+` ×5 → `step` 10, 20, 40, 64, 64. Then `d` ×13 → `x_off[0]` = 800, clamped. Then `-` ×8 → `step` = 1.
- `2` then `a` → `sel` = 2, `x_off[2]` = −5, and channels 0/1/3 unchanged. With `NUM_CH` = 4, `5` → `sel` stays 2.
- Escape sequences:
  - 0x1B,0x5B,0x41 → `y_off[sel]` −= `step`, `key_event` = 4'b1000, 3 bytes echoed.
  - 0x1B,0x78,0x64 → the `x` aborts the sequence, then `d` is applied as a right move.
- Backpressure: hold `tx_ready` = 0 and send 0x77 → `tx_valid` = 1, `rx_ready` = 0, `tx_data` = 0x77 stable. Release → the next byte is accepted the following cycle.
- Reset mid-sequence: after 0x1B,0x5B, assert `rst` for 1 cycle, then send 0x41 → no movement, FSM returned to `S_IDLE`, `tx_valid` cleared by the reset.
